// File: rtl/gpio_pad_ctrl.sv
// GPIO pad controller: registered pad drive (push-pull / open-drain) and a synchronised, glitch-filtered pad input.
// Optional sticky edge interrupt enabled by defining GPIO_IRQ_EN.
module gpio_pad_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYC    = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic out_val,
  input  logic oe,
  input  logic od_mode,
  output logic in_val,
  output logic rise_pulse,
  output logic fall_pulse,
  input  logic irq_rise_en,
  input  logic irq_fall_en,
  input  logic irq_clr,
  output logic irq,
  output logic c2p,
  output logic c2p_en,
  input  logic p2c
);

  localparam int CNT_W = $clog2(FILT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sync_s;
  logic [CNT_W-1:0]       cnt_r;
  logic                   in_val_r;
  logic                   rise_r;
  logic                   fall_r;
  logic                   c2p_r;
  logic                   c2p_en_r;

  // Pad drive: open-drain only ever enables the driver to pull low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c2p_r    <= 1'b0;
      c2p_en_r <= 1'b0;
    end else if (od_mode) begin
      c2p_r    <= 1'b0;
      c2p_en_r <= oe & ~out_val;
    end else begin
      c2p_r    <= out_val;
      c2p_en_r <= oe;
    end
  end

  // Input synchroniser chain for the asynchronous pad level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], p2c};
    end
  end

  assign sync_s = sync_r[SYNC_STAGES-1];

  // Glitch filter: a new level must persist FILT_CYC cycles; any agreement restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r    <= '0;
      in_val_r <= 1'b0;
      rise_r   <= 1'b0;
      fall_r   <= 1'b0;
    end else begin
      rise_r <= 1'b0;
      fall_r <= 1'b0;
      if (sync_s == in_val_r) begin
        cnt_r <= '0;
      end else if (cnt_r == CNT_LAST) begin
        in_val_r <= sync_s;
        cnt_r    <= '0;
        rise_r   <= sync_s;
        fall_r   <= ~sync_s;
      end else begin
        cnt_r <= cnt_r + CNT_ONE;
      end
    end
  end

  assign in_val     = in_val_r;
  assign rise_pulse = rise_r;
  assign fall_pulse = fall_r;
  assign c2p        = c2p_r;
  assign c2p_en     = c2p_en_r;

`ifdef GPIO_IRQ_EN
  logic irq_r;
  logic irq_set_s;

  assign irq_set_s = (rise_r & irq_rise_en) | (fall_r & irq_fall_en);

  // Sticky interrupt; a new event outranks a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= irq_set_s | (irq_r & ~irq_clr);
    end
  end

  assign irq = irq_r;
`else
  logic unused_irq_s;

  assign unused_irq_s = irq_rise_en ^ irq_fall_en ^ irq_clr;
  assign irq          = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Scoreboard bench for gpio_pad_ctrl; expected vectors {c2p,c2p_en,in_val,rise,fall,irq} are queued per cycle.
module tb_gpio_pad_ctrl;

`ifdef GPIO_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic out_val = 1'b0, oe = 1'b0, od_mode = 1'b0;
  logic irq_rise_en = 1'b0, irq_fall_en = 1'b0, irq_clr = 1'b0;
  logic p2c = 1'b0;
  logic in_val, rise_pulse, fall_pulse, irq, c2p, c2p_en;

  logic [5:0] sb_q[$];
  logic [5:0] e;
  logic [5:0] obs;
  int n_checks = 0;
  int n_fail = 0;

  gpio_pad_ctrl dut (
    .clk(clk), .rst_n(rst_n), .out_val(out_val), .oe(oe), .od_mode(od_mode),
    .in_val(in_val), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
    .irq_rise_en(irq_rise_en), .irq_fall_en(irq_fall_en), .irq_clr(irq_clr),
    .irq(irq), .c2p(c2p), .c2p_en(c2p_en), .p2c(p2c)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int k = 1; k <= 3; k++) begin
      sb_q.push_back(6'b000000);
      tick();
      e = sb_q.pop_front();
      obs = {c2p, c2p_en, in_val, rise_pulse, fall_pulse, irq};
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL reset k=%0d: got %b required %b", k, obs, e);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_output_path();
    // {oe, od_mode, out_val}
    logic [2:0] tab [10];
    logic ex_c2p, ex_en;
    tab = '{3'b101, 3'b100, 3'b101, 3'b111, 3'b110, 3'b111, 3'b011, 3'b110, 3'b101, 3'b000};
    for (int k = 0; k < 10; k++) begin
      oe      = tab[k][2];
      od_mode = tab[k][1];
      out_val = tab[k][0];
      ex_c2p  = od_mode ? 1'b0 : out_val;
      ex_en   = od_mode ? (oe & ~out_val) : oe;
      sb_q.push_back({ex_c2p, ex_en, 1'b0, 1'b0, 1'b0, 1'b0});
      tick();
      e = sb_q.pop_front();
      obs = {c2p, c2p_en, in_val, rise_pulse, fall_pulse, irq};
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL output_path step=%0d: got %b required %b", k, obs, e);
      end
    end
    od_mode = 1'b0;
  endtask

  task automatic test_filter_step();
    p2c = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      sb_q.push_back({2'b00, 1'(k >= 10), 1'(k == 10), 1'b0, 1'b0});
      tick();
      e = sb_q.pop_front();
      obs = {c2p, c2p_en, in_val, rise_pulse, fall_pulse, irq};
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL filter_rise k=%0d: got %b required %b", k, obs, e);
      end
    end
    p2c = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      sb_q.push_back({2'b00, 1'(k < 10), 1'b0, 1'(k == 10), 1'b0});
      tick();
      e = sb_q.pop_front();
      obs = {c2p, c2p_en, in_val, rise_pulse, fall_pulse, irq};
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL filter_fall k=%0d: got %b required %b", k, obs, e);
      end
    end
  endtask

  task automatic test_glitch();
    // 7-cycle pulse is rejected
    for (int k = 1; k <= 20; k++) begin
      p2c = (k <= 7);
      sb_q.push_back(6'b000000);
      tick();
      e = sb_q.pop_front();
      obs = {c2p, c2p_en, in_val, rise_pulse, fall_pulse, irq};
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL glitch7 k=%0d: got %b required %b", k, obs, e);
      end
    end
    // 8-cycle pulse is accepted, edges 8 cycles apart
    for (int k = 1; k <= 22; k++) begin
      p2c = (k <= 8);
      sb_q.push_back({2'b00, 1'(k >= 10 && k < 18), 1'(k == 10), 1'(k == 18), 1'b0});
      tick();
      e = sb_q.pop_front();
      obs = {c2p, c2p_en, in_val, rise_pulse, fall_pulse, irq};
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL glitch8 k=%0d: got %b required %b", k, obs, e);
      end
    end
  endtask

  task automatic test_reset_mid_filter();
    oe = 1'b1;
    out_val = 1'b1;
    p2c = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      sb_q.push_back(6'b110000);
      tick();
      e = sb_q.pop_front();
      obs = {c2p, c2p_en, in_val, rise_pulse, fall_pulse, irq};
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL pre_reset k=%0d: got %b required %b", k, obs, e);
      end
    end
    rst_n = 1'b0;
    sb_q.push_back(6'b000000);
    #1;
    e = sb_q.pop_front();
    obs = {c2p, c2p_en, in_val, rise_pulse, fall_pulse, irq};
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL async_reset: got %b required %b", obs, e);
    end
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      sb_q.push_back({2'b11, 1'(k >= 10), 1'(k == 10), 1'b0, 1'b0});
      tick();
      e = sb_q.pop_front();
      obs = {c2p, c2p_en, in_val, rise_pulse, fall_pulse, irq};
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL post_reset_rise k=%0d: got %b required %b", k, obs, e);
      end
    end
    oe = 1'b0;
    out_val = 1'b0;
    p2c = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      sb_q.push_back({2'b00, 1'(k < 10), 1'b0, 1'(k == 10), 1'b0});
      tick();
      e = sb_q.pop_front();
      obs = {c2p, c2p_en, in_val, rise_pulse, fall_pulse, irq};
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL post_reset_fall k=%0d: got %b required %b", k, obs, e);
      end
    end
  endtask

  task automatic test_irq();
    irq_rise_en = 1'b1;
    irq_fall_en = 1'b0;
    p2c = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      sb_q.push_back({2'b00, 1'(k >= 10), 1'(k == 10), 1'b0, IRQ_ON & (k >= 11)});
      tick();
      e = sb_q.pop_front();
      obs = {c2p, c2p_en, in_val, rise_pulse, fall_pulse, irq};
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL irq_rise k=%0d: got %b required %b", k, obs, e);
      end
    end
    p2c = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      sb_q.push_back({2'b00, 1'(k < 10), 1'b0, 1'(k == 10), IRQ_ON});
      tick();
      e = sb_q.pop_front();
      obs = {c2p, c2p_en, in_val, rise_pulse, fall_pulse, irq};
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL irq_fall_hold k=%0d: got %b required %b", k, obs, e);
      end
    end
    // clear coincides with the next set, then stays asserted alone
    p2c = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      if (k == 11) irq_clr = 1'b1;
      sb_q.push_back({2'b00, 1'(k >= 10), 1'(k == 10), 1'b0, IRQ_ON & (k <= 11)});
      tick();
      e = sb_q.pop_front();
      obs = {c2p, c2p_en, in_val, rise_pulse, fall_pulse, irq};
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL irq_clr k=%0d: got %b required %b", k, obs, e);
      end
    end
    irq_clr = 1'b0;
    irq_rise_en = 1'b0;
    p2c = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      sb_q.push_back({2'b00, 1'(k < 10), 1'b0, 1'(k == 10), 1'b0});
      tick();
      e = sb_q.pop_front();
      obs = {c2p, c2p_en, in_val, rise_pulse, fall_pulse, irq};
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL irq_quiet k=%0d: got %b required %b", k, obs, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_output_path();
    test_filter_step();
    test_glitch();
    test_reset_mid_filter();
    test_irq();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
